uart_tx_frame: RTL and testbench

Parametrised UART transmitter with a valid/ready input handshake, a one-entry holding register and configurable frame format (data bits, stop bits, optional parity). It runs entirely in the `clk` domain. A baud counter times each bit, so no derived clock is generated. Sits between any byte producer (test-pattern generator, FIFO, command encoder) and the board's serial TX pin.

---
 rtl/uart_tx_frame.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready input, one-entry holding register, frame timed by a baud counter.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_frame: illegal DATA_BITS, STOP_BITS or PARITY_ODD");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [3:0]           idx_r, idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [DATA_BITS-1:0] hold_r;
  logic                 hold_full_r, hold_full_s;
  logic                 tx_r, tx_s;
  logic                 tx_ready_r, busy_r;
  logic                 load_s, take_s, bit_end_s;

`ifdef UART_TX_PARITY_EN
  logic par_r;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_ODD[0];
  endfunction
`endif

  assign bit_end_s = (cnt_r == CNT_LAST);
  assign take_s    = tx_valid & tx_ready_r;
  assign tx        = tx_r;
  assign tx_ready  = tx_ready_r;
  assign busy      = busy_r;

  // Next-state, next-line-level and bit timing for the frame sequencer
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    load_s  = 1'b0;
    if (state_r == S_IDLE || bit_end_s) begin
      cnt_s = {CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
    case (state_r)
      S_IDLE: begin
        if (hold_full_r) begin
          load_s  = 1'b1;
          shift_s = hold_r;
          state_s = S_START;
          tx_s    = 1'b0;
        end else begin
          tx_s = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_s = S_DATA;
          tx_s    = shift_r[0];
          shift_s = shift_r >> 1;
          idx_s   = 4'd0;
        end else begin
          state_s = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          if (idx_r == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_s = S_PARITY;
            tx_s    = par_r;
`else
            state_s = S_STOP;
            tx_s    = 1'b1;
`endif
            idx_s   = 4'd0;
          end else begin
            tx_s    = shift_r[0];
            shift_s = shift_r >> 1;
            idx_s   = idx_r + 4'd1;
          end
        end else begin
          state_s = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_s = S_STOP;
          tx_s    = 1'b1;
          idx_s   = 4'd0;
        end else begin
          state_s = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_s) begin
          if (idx_r != STOP_LAST) begin
            idx_s = idx_r + 4'd1;
          end else if (hold_full_r) begin
            // chain straight into the next start bit, no idle gap
            load_s  = 1'b1;
            shift_s = hold_r;
            state_s = S_START;
            tx_s    = 1'b0;
          end else begin
            state_s = S_IDLE;
            tx_s    = 1'b1;
          end
        end else begin
          state_s = S_STOP;
        end
      end
      default: begin
        state_s = S_IDLE;
        tx_s    = 1'b1;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Holding-register occupancy after this edge
  always_comb begin
    if (take_s) begin
      hold_full_s = 1'b1;
    end else if (load_s) begin
      hold_full_s = 1'b0;
    end else begin
      hold_full_s = hold_full_r;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= 4'd0;
      shift_r     <= {DATA_BITS{1'b0}};
      hold_r      <= {DATA_BITS{1'b0}};
      hold_full_r <= 1'b0;
      tx_r        <= 1'b1;
      tx_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      shift_r     <= shift_s;
      hold_full_r <= hold_full_s;
      tx_r        <= tx_s;
      tx_ready_r  <= ~hold_full_s;
      busy_r      <= (state_s != S_IDLE) || hold_full_s;
      if (take_s) begin
        hold_r <= tx_data;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the word entering the shifter, captured as it is loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_r <= 1'b0;
    end else if (load_s) begin
      par_r <= parity_bit(hold_r);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: frame-level line model compared every cycle,
// plus directed literal checks. Parity scenarios run when UART_TX_PARITY_EN is defined.
module tb_uart_tx_frame;
  localparam int D = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8:0] din [3];
  logic vld [3];
  logic rdy_o [3];
  logic tx_o [3];
  logic busy_o [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nw [3];
  int acc_e [3][32];
  int st_e [3][32];
  logic [15:0] fbits [3][32];

  initial forever #5 clk = ~clk;

  uart_tx_frame #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .tx_data(din[0][7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]));
  uart_tx_frame #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .tx_data(din[1][6:0]), .tx_valid(vld[1]),
    .tx_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]));
  uart_tx_frame #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .tx_data(din[2][7:0]), .tx_valid(vld[2]),
    .tx_ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]));

  function automatic int db(input int ch);
    return (ch == 1) ? 7 : 8;
  endfunction
  function automatic int sb(input int ch);
    return (ch == 1) ? 2 : 1;
  endfunction
  function automatic int flen(input int ch);
    return 1 + db(ch) + PAR + sb(ch);
  endfunction

  // Frame as a bit list, index 0 = start bit, then payload LSB first, parity, stops
  function automatic logic [15:0] make_frame(input int ch, input logic [8:0] d);
    logic [15:0] f;
    logic p;
    f = 16'hFFFF;
    f[0] = 1'b0;
    p = (ch == 2) ? 1'b1 : 1'b0;
    for (int i = 0; i < db(ch); i++) begin
      f[1 + i] = d[i];
      p = p ^ d[i];
    end
`ifdef UART_TX_PARITY_EN
    f[1 + db(ch)] = p;
`endif
    return f;
  endfunction

  function automatic logic m_ready(input int ch, input int t);
    for (int i = 0; i < nw[ch]; i++)
      if (acc_e[ch][i] <= t && st_e[ch][i] > t) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic m_busy(input int ch, input int t);
    for (int i = 0; i < nw[ch]; i++)
      if (acc_e[ch][i] <= t && t < st_e[ch][i] + flen(ch) * D) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic m_tx(input int ch, input int t);
    logic [15:0] f;
    for (int i = 0; i < nw[ch]; i++)
      if (st_e[ch][i] <= t && t < st_e[ch][i] + flen(ch) * D) begin
        f = fbits[ch][i];
        return f[(t - st_e[ch][i]) / D];
      end
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: edge counter and accepted words with their scheduled start edges
  initial forever begin
    @(posedge clk);
    if (rst) begin
      cyc = 0;
      for (int c = 0; c < 3; c++) nw[c] = 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (vld[c] && m_ready(c, cyc) && nw[c] < 32) begin
          int last_end;
          last_end = (nw[c] > 0) ? st_e[c][nw[c]-1] + flen(c) * D : 0;
          acc_e[c][nw[c]] = cyc + 1;
          st_e[c][nw[c]]  = (cyc + 2 > last_end) ? cyc + 2 : last_end;
          fbits[c][nw[c]] = make_frame(c, din[c]);
          nw[c]++;
        end
      end
      cyc = cyc + 1;
    end
  end

  // Compare every DUT output against the model on each falling edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("ch%0d tx", c), tx_o[c], m_tx(c, cyc));
        chk($sformatf("ch%0d tx_ready", c), rdy_o[c], m_ready(c, cyc));
        chk($sformatf("ch%0d busy", c), busy_o[c], m_busy(c, cyc));
      end
    end
  end

  task automatic wait_edge(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) begin
      checks++;
      errors++;
      $display("FAIL wait_edge timeout: at edge %0d, wanted %0d", cyc, n);
    end
  endtask

  task automatic send(input int ch, input logic [8:0] d, input bit keep, output int e);
    int n0, g;
    @(negedge clk);
    din[ch] = d;
    vld[ch] = 1'b1;
    n0 = nw[ch];
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while (nw[ch] == n0 && g < 1000);
    if (nw[ch] == n0) begin
      checks++;
      errors++;
      $display("FAIL send ch%0d: word %0h never accepted", ch, d);
      e = cyc;
    end else begin
      e = acc_e[ch][nw[ch]-1];
    end
    if (!keep) begin
      @(negedge clk);
      vld[ch] = 1'b0;
    end
  endtask

  task automatic decode(input int ch, input int nd, input int ns,
                        output logic [8:0] d, output logic p, output int s);
    int g;
    g = 0;
    d = 9'h000;
    p = 1'b0;
    do begin
      @(negedge clk);
      g++;
    end while (tx_o[ch] !== 1'b0 && g < 3000);
    s = cyc;
    if (tx_o[ch] !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL decode ch%0d: no start bit, tx=%b expected 0", ch, tx_o[ch]);
      return;
    end
    for (int i = 0; i < nd; i++) begin
      wait_edge(s + D * (1 + i) + D / 2);
      d[i] = tx_o[ch];
    end
`ifdef UART_TX_PARITY_EN
    wait_edge(s + D * (1 + nd) + D / 2);
    p = tx_o[ch];
`endif
    for (int j = 0; j < ns; j++) begin
      wait_edge(s + D * (1 + nd + PAR + j) + D / 2);
      chk($sformatf("ch%0d stop%0d", ch, j), tx_o[ch], 1);
    end
  endtask

  initial begin
    int e1, e2, s1, s2, len;
    logic [8:0] w1, w2;
    logic p1, p2;
    logic [10:0] exp55;
    for (int c = 0; c < 3; c++) begin
      din[c] = 9'h000;
      vld[c] = 1'b0;
    end
    len = 10 + PAR;
    exp55 = (PAR == 1) ? 11'b10010101010 : 11'b01010101010;

    // Reset values, then 500 idle cycles
    repeat (3) @(negedge clk);
    chk("reset tx", tx_o[0], 1);
    chk("reset tx_ready", rdy_o[0], 1);
    chk("reset busy", busy_o[0], 0);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    chk("idle tx", tx_o[0], 1);
    chk("idle tx_ready", rdy_o[0], 1);
    chk("idle busy", busy_o[0], 0);

    // Single 0x55: exact timing against hand-computed bits
    send(0, 9'h055, 1'b0, e1);
    chk("0x55 ready after E", rdy_o[0], 0);
    chk("0x55 busy after E", busy_o[0], 1);
    chk("0x55 tx after E", tx_o[0], 1);
    wait_edge(e1 + 1);
    chk("0x55 start at E+1", tx_o[0], 0);
    chk("0x55 ready at E+1", rdy_o[0], 1);
    for (int i = 0; i < len; i++) begin
      wait_edge(e1 + 1 + D * i + D / 2);
      chk($sformatf("0x55 bit%0d", i), tx_o[0], exp55[i]);
    end
    wait_edge(e1 + len * D);
    chk("0x55 busy last cycle", busy_o[0], 1);
    wait_edge(e1 + 1 + len * D);
    chk("0x55 busy fall", busy_o[0], 0);

    // Back-to-back 0xA3, 0x0F with tx_valid held high
    fork
      begin
        send(0, 9'h0A3, 1'b1, e1);
        send(0, 9'h00F, 1'b0, e2);
      end
      begin
        decode(0, 8, 1, w1, p1, s1);
        decode(0, 8, 1, w2, p2, s2);
      end
    join
    chk("b2b second handshake", e2 - e1, 2);
    chk("b2b first start", s1 - e1, 1);
    chk("b2b no gap", s2 - s1, len * D);
    chk("b2b word1", w1, 9'h0A3);
    chk("b2b word2", w2, 9'h00F);

    // 0x07: parity selection, frame length
    fork
      send(0, 9'h007, 1'b0, e1);
      decode(0, 8, 1, w1, p1, s1);
    join
    chk("0x07 even data", w1, 9'h007);
    fork
      send(2, 9'h007, 1'b0, e2);
      decode(2, 8, 1, w2, p2, s2);
    join
    chk("0x07 odd data", w2, 9'h007);
`ifdef UART_TX_PARITY_EN
    chk("0x07 even parity", p1, 1);
    chk("0x07 odd parity", p2, 0);
`endif
    wait_edge(s2 + len * D - 1);
    chk("0x07 busy last cycle", busy_o[2], 1);
    wait_edge(s2 + len * D);
    chk("0x07 busy fall", busy_o[2], 0);

    // 7 data bits, 2 stop bits, payload 0x7F
    send(1, 9'h07F, 1'b0, e1);
    s1 = e1 + 1;
    wait_edge(s1 + D / 2);
    chk("7E2 start", tx_o[1], 0);
    wait_edge(s1 + (8 + PAR) * D);
    chk("7E2 stop first cycle", tx_o[1], 1);
    wait_edge(s1 + (10 + PAR) * D - 1);
    chk("7E2 stop last cycle", tx_o[1], 1);
    chk("7E2 busy last cycle", busy_o[1], 1);
    wait_edge(s1 + (10 + PAR) * D);
    chk("7E2 busy fall", busy_o[1], 0);

    // Reset in the middle of data bit 3 of 0x35 (bit 3 is 0)
    send(0, 9'h035, 1'b0, e1);
    wait_edge(e1 + 1 + D * 4 + 5);
    chk("pre-reset bit3", tx_o[0], 0);
    #1 rst = 1'b1;
    #1 chk("async reset tx", tx_o[0], 1);
    @(negedge clk);
    chk("reset tx_ready", rdy_o[0], 1);
    chk("reset busy", busy_o[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fork
      send(0, 9'h096, 1'b0, e2);
      decode(0, 8, 1, w1, p1, s1);
    join
    chk("post-reset word", w1, 9'h096);
    chk("post-reset start", s1 - e2, 1);
    wait_edge(s1 + len * D + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
